// File: rtl/pwm_pkg.sv
// Shared types for the PWM fade scheduler: channel modes, breathe direction,
// sweep FSM states and the 16-bit duty type.
package pwm_pkg;

  localparam int DUTY_W = 16;

  typedef logic [DUTY_W-1:0] duty_t;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

endpackage

// File: rtl/pwm_fade_channel.sv
// Combinational service rule for one channel: given mode, shadow duty and
// breathe direction, produce the next shadow duty and direction.
module pwm_fade_channel
  import pwm_pkg::*;
#(
  parameter int DUTY_MAX  = 14000,
  parameter int DUTY_STEP = 1
) (
  input  logic [1:0]        mode,
  input  logic [DUTY_W-1:0] shadow,
  input  logic              dir,
  output logic [DUTY_W-1:0] next_shadow,
  output logic              next_dir
);

  localparam duty_t MAX_D  = duty_t'(DUTY_MAX);
  localparam duty_t STEP_D = duty_t'(DUTY_STEP);

  // One extra bit so the upward step saturates instead of wrapping.
  logic [DUTY_W:0] up_sum;
  assign up_sum = {1'b0, shadow} + {1'b0, STEP_D};

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    next_shadow = shadow;
    next_dir    = dir;
    case (mode_e'(mode))
      MODE_OFF: next_shadow = '0;
      MODE_ON:  next_shadow = MAX_D;
      MODE_BREATHE: begin
        if (dir == DIR_UP) begin
          if (up_sum >= {1'b0, MAX_D}) begin
            next_shadow = MAX_D;
            next_dir    = DIR_DOWN;
          end else begin
            next_shadow = up_sum[DUTY_W-1:0];
          end
        end else begin
          if (shadow <= STEP_D) begin
            next_shadow = '0;
            next_dir    = DIR_UP;
          end else begin
            next_shadow = shadow - STEP_D;
          end
        end
      end
      MODE_BLINK: next_shadow = (shadow != '0) ? '0 : MAX_D;
      default:    next_shadow = shadow;
    endcase
  end

endmodule

// File: rtl/pwm_fade_scheduler.sv
// Multi-channel LED dimmer: shared PWM period counter, one shared duty-update
// engine swept round-robin every step interval, and a one-deep command slot.
module pwm_fade_scheduler
  import pwm_pkg::*;
#(
  parameter int NUM_CH      = 8,
  parameter int PWM_PERIOD  = 20000,
  parameter int STEP_CYCLES = 3125000,
  parameter int DUTY_MAX    = 14000,
  parameter int DUTY_STEP   = 1,
  // One spare code so out-of-range channel numbers can be presented and discarded.
  localparam int CH_W       = $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [1:0]        cmd_mode,
  output logic [NUM_CH-1:0] leds,
  output logic              frame_start
);

  localparam int                IDX_W    = $clog2(NUM_CH);
  localparam int                TMR_W    = $clog2(STEP_CYCLES);
  localparam duty_t             CNT_LAST = duty_t'(PWM_PERIOD - 1);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_CH - 1);
  localparam logic [CH_W-1:0]   CH_LIMIT = CH_W'(NUM_CH);

  duty_t             cnt;
  logic [TMR_W-1:0]  tmr;
  state_e            state;
  logic [IDX_W-1:0]  svc_idx;

  logic              pend_valid;
  logic [IDX_W-1:0]  pend_ch;
  mode_e             pend_mode;

  mode_e             mode_q   [NUM_CH];
  duty_t             shadow_q [NUM_CH];
  duty_t             active_q [NUM_CH];
  logic [NUM_CH-1:0] dir_q;

  logic              cnt_wrap;
  logic              step_tc;
  logic              apply;
  mode_e             svc_mode;
  logic              svc_dir;
  duty_t             svc_shadow_next;
  logic              svc_dir_next;

  assign cnt_wrap  = (cnt == CNT_LAST);
  assign step_tc   = (tmr == TMR_LAST);
  assign apply     = (state == ST_SWEEP) && pend_valid && (pend_ch == svc_idx);
  assign cmd_ready = ~pend_valid;

  // A pending command takes effect in its own channel's slot, with the new mode.
  always_comb begin
    svc_mode = mode_q[svc_idx];
    svc_dir  = dir_q[svc_idx];
    if (apply) begin
      svc_mode = pend_mode;
      if (pend_mode == MODE_BREATHE && mode_q[svc_idx] != MODE_BREATHE) svc_dir = DIR_UP;
    end
  end

  pwm_fade_channel #(
    .DUTY_MAX  (DUTY_MAX),
    .DUTY_STEP (DUTY_STEP)
  ) u_svc (
    .mode        (svc_mode),
    .shadow      (shadow_q[svc_idx]),
    .dir         (svc_dir),
    .next_shadow (svc_shadow_next),
    .next_dir    (svc_dir_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      frame_start <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      cnt         <= cnt_wrap ? '0 : cnt + 1'b1;
      frame_start <= cnt_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr     <= '0;
      state   <= ST_IDLE;
      svc_idx <= '0;
    end else begin
      tmr <= step_tc ? '0 : tmr + 1'b1;
      case (state)
        ST_IDLE: begin
          if (step_tc) begin
            state   <= ST_SWEEP;
            svc_idx <= '0;
          end
        end
        ST_SWEEP: begin
          if (svc_idx == IDX_LAST) state <= ST_IDLE;
          else                     svc_idx <= svc_idx + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_ch    <= '0;
      pend_mode  <= MODE_OFF;
    end else if (apply) begin
      pend_valid <= 1'b0;
    end else if (cmd_valid && cmd_ready) begin
      pend_valid <= (cmd_ch < CH_LIMIT);
      pend_ch    <= IDX_W'(cmd_ch);
      pend_mode  <= mode_e'(cmd_mode);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the per-channel arrays are a few flops each, so they are reset like any other state.
      for (int k = 0; k < NUM_CH; k++) begin
        mode_q[k]   <= MODE_OFF;
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      dir_q <= '0;
    end else begin
      if (state == ST_SWEEP) begin
        mode_q[svc_idx]   <= svc_mode;
        shadow_q[svc_idx] <= svc_shadow_next;
        dir_q[svc_idx]    <= svc_dir_next;
      end
      // Duty changes only at the frame boundary so a pulse is never cut short.
      if (cnt_wrap) begin
        for (int k = 0; k < NUM_CH; k++) active_q[k] <= shadow_q[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) leds[k] <= (cnt < active_q[k]);
    end
  end

endmodule
